// File: rtl/ei_axi4_pkg.sv
// ----------------------------------------------------------------------------
// ei_axi4_pkg
// Shared AXI4 encodings for the ei_axi4 slice: burst types, response codes
// and the write/read FSM state enums of the slave memory endpoint.
// No ports.
// ----------------------------------------------------------------------------
package ei_axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// ----------------------------------------------------------------------------
// ei_axi4_addr_gen
// Purely combinational next-beat address calculator for one AXI4 burst.
//   addr_i  : address of the current beat
//   len_i   : AxLEN of the burst (beats = len_i + 1)
//   size_i  : AxSIZE (bytes per beat = 2**size_i)
//   burst_i : AxBURST encoding
//   next_o  : address of the following beat
// The reserved burst type leaves the address unchanged; the caller flags it.
// ----------------------------------------------------------------------------
module ei_axi4_addr_gen
   import ei_axi4_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   output logic [ADDR_WIDTH-1:0] next_o
);

   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] sum;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      incr      = ADDR_WIDTH'(1) << size_i;
      sum       = addr_i + incr;
      // Wrap window is (len+1) beats, aligned to its own size; the upper
      // address bits stay fixed and only the in-window offset rolls over.
      wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
      case (burst_i)
         BURST_INCR: next_o = sum;
         BURST_WRAP: next_o = (addr_i & ~wrap_mask) | (sum & wrap_mask);
         default:    next_o = addr_i;
      endcase
   end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// ----------------------------------------------------------------------------
// ei_axi4_slave_mem
// AXI4 slave memory endpoint, one outstanding burst per direction, with
// independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs.
//   aclk, areset                       : clock, synchronous active-high reset
//   aw*  (id/addr/len/size/burst/valid/ready) : write address channel
//   w*   (data/strb/last/valid/ready)  : write data channel
//   b*   (id/resp/valid/ready)         : write response channel
//   ar*  (id/addr/len/size/burst/valid/ready) : read address channel
//   r*   (id/data/resp/last/valid/ready) : read data channel
// Storage is one byte-wide array per byte lane (byte enables) with a
// registered read port; the memory itself is never reset.
// ----------------------------------------------------------------------------
module ei_axi4_slave_mem
   import ei_axi4_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int WORD_LSB = $clog2(STRB_W);
   localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

   // A beat may touch memory only for a legal burst type, a size no wider
   // than the bus, and a word index inside the array.
   function automatic logic legal_beat(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
      legal_beat = (burst != BURST_RSVD) && (size <= 3'(WORD_LSB)) &&
                   ((addr >> WORD_LSB) < DEPTH_A);
   endfunction

   // ---------------- write side ----------------
   wr_state_e             w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   awid_q;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_next;
   logic [7:0]            awlen_q, wcnt_q;
   logic [2:0]            awsize_q;
   logic [1:0]            awburst_q;
   logic                  werr_q;
   logic                  aw_hs, w_hs, b_hs, w_final, w_ok, mem_we;
   logic [IDX_W-1:0]      widx;

   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign b_hs    = bvalid && bready;
   assign w_final = (wcnt_q == 8'd0);
   assign w_ok    = legal_beat(waddr_q, awsize_q, awburst_q);
   assign mem_we  = w_hs && w_ok && !areset;
   assign widx    = waddr_q[IDX_W+WORD_LSB-1:WORD_LSB];

   ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
      .addr_i (waddr_q),
      .len_i  (awlen_q),
      .size_i (awsize_q),
      .burst_i(awburst_q),
      .next_o (waddr_next)
   );

   always_ff @(posedge aclk) begin
      if (areset) w_state_q <= W_IDLE;
      else        w_state_q <= w_state_d;
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_hs) w_state_d = W_DATA;
         W_DATA:  if (w_hs && w_final) w_state_d = W_RESP;
         W_RESP:  if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (w_state_q == W_IDLE);
      wready  = (w_state_q == W_DATA);
      bvalid  = (w_state_q == W_RESP);
      bresp   = (bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
      bid     = awid_q;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         awid_q    <= '0;
         waddr_q   <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
      end else if (aw_hs) begin
         awid_q    <= awid;
         waddr_q   <= awaddr;
         awlen_q   <= awlen;
         awsize_q  <= awsize;
         awburst_q <= awburst;
         wcnt_q    <= awlen;
         werr_q    <= 1'b0;
      end else if (w_hs) begin
         waddr_q <= waddr_next;
         wcnt_q  <= wcnt_q - 8'd1;
         // Sticky: any illegal beat or wlast disagreeing with the counter.
         werr_q  <= werr_q | !w_ok | (wlast != w_final);
      end
   end

   // ---------------- read side ----------------
   rd_state_e             r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   arid_q;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_next, rd_addr;
   logic [7:0]            arlen_q, rcnt_q;
   logic [2:0]            arsize_q;
   logic [1:0]            arburst_q;
   logic                  rerr_q;
   logic                  ar_hs, r_hs, r_final, mem_re, rd_ok;
   logic [IDX_W-1:0]      ridx;
   logic [DATA_WIDTH-1:0] rd_word;

   assign ar_hs   = arvalid && arready;
   assign r_hs    = rvalid && rready;
   assign r_final = (rcnt_q == 8'd0);
   // The memory read for a beat is launched on the edge that makes it
   // current, so data is ready the cycle rvalid presents it and stays
   // frozen while the master stalls.
   assign mem_re  = ar_hs || (r_hs && !r_final);
   assign rd_addr = ar_hs ? araddr : raddr_next;
   assign rd_ok   = ar_hs ? legal_beat(araddr, arsize, arburst)
                          : legal_beat(raddr_next, arsize_q, arburst_q);
   assign ridx    = rd_addr[IDX_W+WORD_LSB-1:WORD_LSB];

   ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
      .addr_i (raddr_q),
      .len_i  (arlen_q),
      .size_i (arsize_q),
      .burst_i(arburst_q),
      .next_o (raddr_next)
   );

   always_ff @(posedge aclk) begin
      if (areset) r_state_q <= R_IDLE;
      else        r_state_q <= r_state_d;
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (r_hs && r_final) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_DATA);
      rlast   = rvalid && r_final;
      rresp   = (rvalid && rerr_q) ? RESP_SLVERR : RESP_OKAY;
      rdata   = (rvalid && !rerr_q) ? rd_word : '0;
      rid     = arid_q;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         arid_q    <= '0;
         raddr_q   <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         rcnt_q    <= '0;
         rerr_q    <= 1'b0;
      end else if (ar_hs) begin
         arid_q    <= arid;
         raddr_q   <= araddr;
         arlen_q   <= arlen;
         arsize_q  <= arsize;
         arburst_q <= arburst;
         rcnt_q    <= arlen;
         rerr_q    <= !rd_ok;
      end else if (r_hs && !r_final) begin
         raddr_q <= raddr_next;
         rcnt_q  <= rcnt_q - 8'd1;
         rerr_q  <= !rd_ok;   // error status is per beat, not sticky
      end
   end

   // ---------------- storage: one array per byte lane ----------------
   // Read and write share the edge, so a same-cycle read sees old contents.
   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane
         logic [7:0] lane_q [MEM_DEPTH];
         logic [7:0] rd_byte_q;

         always_ff @(posedge aclk) begin
            if (mem_we && wstrb[gi]) lane_q[widx] <= wdata[gi*8 +: 8];
            if (mem_re) rd_byte_q <= lane_q[ridx];
         end

         assign rd_word[gi*8 +: 8] = rd_byte_q;
      end
   endgenerate

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
module tb_ei_axi4_slave_mem;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   b_exp_t bq[$];
   r_exp_t rq[$];

   ei_axi4_slave_mem dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   // Monitor: compares every presented B/R beat (including stalled cycles,
   // which checks stability) against the head of its queue; pops on handshake.
   initial begin
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (bvalid) begin
               if (bq.size() == 0) timeout("b_unexpected");
               else begin
                  chk("bid", 64'(bid), 64'(bq[0].id));
                  chk("bresp", 64'(bresp), 64'(bq[0].resp));
                  if (bready) begin
                     $display("B  id=%0h resp=%0b", bid, bresp);
                     void'(bq.pop_front());
                  end
               end
            end
            if (rvalid) begin
               if (rq.size() == 0) timeout("r_unexpected");
               else begin
                  chk("rid", 64'(rid), 64'(rq[0].id));
                  chk("rdata", 64'(rdata), 64'(rq[0].data));
                  chk("rresp", 64'(rresp), 64'(rq[0].resp));
                  chk("rlast", 64'(rlast), 64'(rq[0].last));
                  if (rready) begin
                     $display("R  id=%0h data=%08h resp=%0b last=%0b", rid, rdata, rresp, rlast);
                     void'(rq.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic exp_r(input logic [3:0] id, input logic [31:0] d,
                        input logic [1:0] resp, input logic last);
      r_exp_t e;
      e.id = id; e.data = d; e.resp = resp; e.last = last;
      rq.push_back(e);
   endtask

   // Issues AW then len+1 W beats (data d0+i). Pushes the expected B first.
   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] d0, input logic [3:0] strb,
                              input logic [3:0] id, input logic [1:0] resp,
                              input bit early_last);
      b_exp_t e;
      int n;
      e.id = id; e.resp = resp;
      bq.push_back(e);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!awready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) timeout("aw_wait");
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = d0 + 32'(i); wstrb = strb;
         wlast = early_last ? (i == 0) : (i == int'(len));
         wvalid = 1'b1;
         n = 0;
         @(negedge aclk);
         while (!wready && n < 200) begin @(negedge aclk); n++; end
         if (n >= 200) timeout("w_wait");
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] id);
      int n;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!arready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) timeout("ar_wait");
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 500) begin
         @(posedge aclk); n++;
      end
      #1;
      if (n >= 500) timeout("drain");
   endtask

   initial begin
      int n;
      areset = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b1;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;

      // Reset state
      @(negedge aclk);
      chk("rst_awready", 64'(awready), 64'd1);
      chk("rst_arready", 64'(arready), 64'd1);
      chk("rst_wready",  64'(wready),  64'd0);
      chk("rst_bvalid",  64'(bvalid),  64'd0);
      chk("rst_rvalid",  64'(rvalid),  64'd0);
      chk("rst_rlast",   64'(rlast),   64'd0);
      chk("rst_rdata",   64'(rdata),   64'd0);
      chk("rst_bresp",   64'(bresp),   64'd0);
      @(posedge aclk); #1;

      // INCR write/read of four words at 0x10
      write_burst(32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 4'd1, 2'b00, 1'b0);
      exp_r(4'd2, 32'hA0, 2'b00, 1'b0);
      exp_r(4'd2, 32'hA1, 2'b00, 1'b0);
      exp_r(4'd2, 32'hA2, 2'b00, 1'b0);
      exp_r(4'd2, 32'hA3, 2'b00, 1'b1);
      read_burst(32'h10, 8'd3, 3'd2, 2'b01, 4'd2);

      // WRAP read: 0x18, 0x1C, 0x10, 0x14
      exp_r(4'd6, 32'hA2, 2'b00, 1'b0);
      exp_r(4'd6, 32'hA3, 2'b00, 1'b0);
      exp_r(4'd6, 32'hA0, 2'b00, 1'b0);
      exp_r(4'd6, 32'hA1, 2'b00, 1'b1);
      read_burst(32'h18, 8'd3, 3'd2, 2'b10, 4'd6);

      // Partial strobe merge
      write_burst(32'h80, 8'd0, 3'd2, 2'b01, 32'h12345678, 4'hF, 4'd7, 2'b00, 1'b0);
      write_burst(32'h80, 8'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'b0011, 4'd7, 2'b00, 1'b0);
      exp_r(4'd8, 32'h1234FFFF, 2'b00, 1'b1);
      read_burst(32'h80, 8'd0, 3'd2, 2'b01, 4'd8);

      // Out-of-range write must not alias onto word 0
      write_burst(32'h0, 8'd0, 3'd2, 2'b01, 32'h0BADF00D, 4'hF, 4'd9, 2'b00, 1'b0);
      write_burst(32'h400, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 4'd9, 2'b10, 1'b0);
      exp_r(4'd10, 32'h0, 2'b10, 1'b1);
      read_burst(32'h400, 8'd0, 3'd2, 2'b01, 4'd10);
      exp_r(4'd11, 32'h0BADF00D, 2'b00, 1'b1);
      read_burst(32'h0, 8'd0, 3'd2, 2'b01, 4'd11);

      // FIXED burst: all beats land on one word
      write_burst(32'h30, 8'd2, 3'd2, 2'b00, 32'hD0, 4'hF, 4'd12, 2'b00, 1'b0);
      exp_r(4'd13, 32'hD2, 2'b00, 1'b0);
      exp_r(4'd13, 32'hD2, 2'b00, 1'b1);
      read_burst(32'h30, 8'd1, 3'd2, 2'b00, 4'd13);

      // Early wlast: SLVERR but data still written, FSM follows counter
      write_burst(32'h60, 8'd1, 3'd2, 2'b01, 32'hE0, 4'hF, 4'd14, 2'b10, 1'b1);
      exp_r(4'd15, 32'hE0, 2'b00, 1'b0);
      exp_r(4'd15, 32'hE1, 2'b00, 1'b1);
      read_burst(32'h60, 8'd1, 3'd2, 2'b01, 4'd15);

      // Oversized beat suppresses the write
      write_burst(32'h70, 8'd0, 3'd2, 2'b01, 32'h70707070, 4'hF, 4'd1, 2'b00, 1'b0);
      write_burst(32'h70, 8'd0, 3'd3, 2'b01, 32'h77777777, 4'hF, 4'd1, 2'b10, 1'b0);
      exp_r(4'd2, 32'h70707070, 2'b00, 1'b1);
      read_burst(32'h70, 8'd0, 3'd2, 2'b01, 4'd2);

      // Reserved burst read: every beat errors with zero data
      exp_r(4'd3, 32'h0, 2'b10, 1'b0);
      exp_r(4'd3, 32'h0, 2'b10, 1'b1);
      read_burst(32'h10, 8'd1, 3'd2, 2'b11, 4'd3);
      drain();

      // B stall: bready low, awready must stay low, B held stable
      bready = 1'b0;
      write_burst(32'h20, 8'd1, 3'd2, 2'b01, 32'h5A00, 4'hF, 4'd3, 2'b00, 1'b0);
      repeat (5) begin
         @(negedge aclk);
         chk("stall_bvalid", 64'(bvalid), 64'd1);
         chk("stall_awready", 64'(awready), 64'd0);
      end
      @(posedge aclk); #1 bready = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      chk("post_b_awready", 64'(awready), 64'd1);
      @(posedge aclk); #1;

      // R stall: rready toggles every cycle during an INCR read
      exp_r(4'd4, 32'hA0, 2'b00, 1'b0);
      exp_r(4'd4, 32'hA1, 2'b00, 1'b0);
      exp_r(4'd4, 32'hA2, 2'b00, 1'b0);
      exp_r(4'd4, 32'hA3, 2'b00, 1'b1);
      fork
         read_burst(32'h10, 8'd3, 3'd2, 2'b01, 4'd4);
         repeat (14) begin @(posedge aclk); #1 rready = ~rready; end
      join
      rready = 1'b1;
      drain();

      // Reset after 2 of 4 write beats
      write_burst(32'h48, 8'd1, 3'd2, 2'b01, 32'h11111111, 4'hF, 4'd5, 2'b00, 1'b0);
      drain();
      awid = 4'd5; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
      awvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!awready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) timeout("aw_wait_rst");
      @(posedge aclk); #1 awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wdata = 32'hC0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
         n = 0;
         @(negedge aclk);
         while (!wready && n < 200) begin @(negedge aclk); n++; end
         if (n >= 200) timeout("w_wait_rst");
         @(posedge aclk); #1;
      end
      wvalid = 1'b0;
      areset = 1'b1;
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      chk("rel_awready", 64'(awready), 64'd1);
      chk("rel_bvalid", 64'(bvalid), 64'd0);
      chk("rel_wready", 64'(wready), 64'd0);
      repeat (3) begin
         @(negedge aclk);
         chk("rel_no_bvalid", 64'(bvalid), 64'd0);
      end
      @(posedge aclk); #1;
      exp_r(4'd6, 32'hC0, 2'b00, 1'b0);
      exp_r(4'd6, 32'hC1, 2'b00, 1'b0);
      exp_r(4'd6, 32'h11111111, 2'b00, 1'b0);
      exp_r(4'd6, 32'h11111112, 2'b00, 1'b1);
      read_burst(32'h40, 8'd3, 3'd2, 2'b01, 4'd6);
      drain();

      chk("bq_empty", 64'(bq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
